// File: rtl/demux_rr_param.sv
// Parametrised lane demultiplexer: each input lane fans out round-robin or by direct select to RATIO registered output lanes.
// Optional per-output handshake counters (beat_cnt port) are compiled in when DEMUX_RR_STATS_EN is defined.
module demux_rr_param #(
    parameter int WIDTH = 8,
    parameter int IN_CH = 2,
    parameter int RATIO = 2,
    localparam int OUT_CH = IN_CH * RATIO,
    localparam int SELW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [IN_CH-1:0]          valid_in,
    input  logic [IN_CH*WIDTH-1:0]    data_in,
    input  logic [IN_CH*SELW-1:0]     sel_in,
    output logic [IN_CH-1:0]          ready_in,
    output logic [OUT_CH-1:0]         valid_out,
    output logic [OUT_CH*WIDTH-1:0]   data_out,
    input  logic [OUT_CH-1:0]         ready_out
`ifdef DEMUX_RR_STATS_EN
   ,output logic [OUT_CH*16-1:0]      beat_cnt
`endif
);

    for (genvar gi = 0; gi < IN_CH; gi++) begin : g_lane
        logic [SELW-1:0] ptr_q, ptr_d;
        logic [SELW-1:0] tgt;
        logic            rdy;
        logic            acc;

        assign tgt = mode ? sel_in[gi*SELW +: SELW] : ptr_q;

        // An out-of-range select matches no lane, so the beat is accepted and dropped.
        always_comb begin
            rdy = 1'b1;
            for (int k = 0; k < RATIO; k++) begin
                if (tgt == SELW'(k)) begin
                    rdy = !valid_out[gi*RATIO + k] || ready_out[gi*RATIO + k];
                end
            end
        end

        assign ready_in[gi] = rdy;
        assign acc          = valid_in[gi] && rdy;

        always_comb begin
            ptr_d = ptr_q;
            if (!mode && acc) begin
                ptr_d = (ptr_q == SELW'(RATIO - 1)) ? '0 : ptr_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        for (genvar gk = 0; gk < RATIO; gk++) begin : g_out
            localparam int J = gi * RATIO + gk;

            logic             ld;
            logic             vq, vd;
            logic [WIDTH-1:0] dq, dd;

            assign ld = acc && (tgt == SELW'(gk));

            // A load wins over a drain, giving one beat per cycle through a single stage.
            always_comb begin
                vd = vq;
                dd = dq;
                if (ld) begin
                    vd = 1'b1;
                    dd = data_in[gi*WIDTH +: WIDTH];
                end else if (vq && ready_out[J]) begin
                    vd = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vq <= 1'b0;
                    dq <= '0;
                end else begin
                    vq <= vd;
                    dq <= dd;
                end
            end

            assign valid_out[J]                = vq;
            assign data_out[J*WIDTH +: WIDTH]  = dq;

`ifdef DEMUX_RR_STATS_EN
            logic [15:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (vq && ready_out[J] && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign beat_cnt[J*16 +: 16] = cnt_q;
`endif
        end
    end

endmodule

// File: tb/tb_demux_rr_param.sv
// Directed-vector bench for demux_rr_param: a 2x2 instance for the main table and a 2x3 instance for the non-power-of-two wrap.
module tb_demux_rr_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance: WIDTH=8, IN_CH=2, RATIO=2.
    logic        mode;
    logic [1:0]  valid_in;
    logic [15:0] data_in;
    logic [1:0]  sel_in;
    logic [1:0]  ready_in;
    logic [3:0]  valid_out;
    logic [31:0] data_out;
    logic [3:0]  ready_out;

    // RATIO=3 instance.
    logic        mode3;
    logic [1:0]  valid_in3;
    logic [15:0] data_in3;
    logic [3:0]  sel_in3;
    logic [1:0]  ready_in3;
    logic [5:0]  valid_out3;
    logic [47:0] data_out3;
    logic [5:0]  ready_out3;

`ifdef DEMUX_RR_STATS_EN
    logic [63:0] beat_cnt;
    logic [95:0] beat_cnt3;
`endif

    demux_rr_param #(.WIDTH(8), .IN_CH(2), .RATIO(2)) dut (
        .clk(clk), .reset(rst), .mode(mode), .valid_in(valid_in), .data_in(data_in),
        .sel_in(sel_in), .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
        .ready_out(ready_out)
`ifdef DEMUX_RR_STATS_EN
       ,.beat_cnt(beat_cnt)
`endif
    );

    demux_rr_param #(.WIDTH(8), .IN_CH(2), .RATIO(3)) dut3 (
        .clk(clk), .reset(rst), .mode(mode3), .valid_in(valid_in3), .data_in(data_in3),
        .sel_in(sel_in3), .ready_in(ready_in3), .valid_out(valid_out3), .data_out(data_out3),
        .ready_out(ready_out3)
`ifdef DEMUX_RR_STATS_EN
       ,.beat_cnt(beat_cnt3)
`endif
    );

    typedef struct packed {
        logic        mode;
        logic [1:0]  vin;
        logic [15:0] din;
        logic [1:0]  sel;
        logic [3:0]  rout;
        logic [1:0]  exp_rin;
        logic [3:0]  exp_vout;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl [19];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector, check ready_in before the edge and the registered outputs after it.
    task automatic step(input vec_t v, input int idx);
        mode      = v.mode;
        valid_in  = v.vin;
        data_in   = v.din;
        sel_in    = v.sel;
        ready_out = v.rout;
        #1;
        check($sformatf("v%0d ready_in", idx), {94'd0, ready_in}, {94'd0, v.exp_rin});
        @(posedge clk);
        #1;
        check($sformatf("v%0d valid_out", idx), {92'd0, valid_out}, {92'd0, v.exp_vout});
        check($sformatf("v%0d data_out", idx), {64'd0, data_out}, {64'd0, v.exp_dout});
        $display("vec %0d: mode=%0b vin=%b din=%h rout=%b -> rin=%b vout=%b dout=%h",
                 idx, v.mode, v.vin, v.din, v.rout, ready_in, valid_out, data_out);
    endtask

    task automatic idle_inputs();
        mode = 1'b0; valid_in = '0; data_in = '0; sel_in = '0; ready_out = 4'hF;
        mode3 = 1'b0; valid_in3 = '0; data_in3 = '0; sel_in3 = '0; ready_out3 = 6'h3F;
    endtask

    initial begin
        //            mode vin    din        sel    rout   rin    vout     dout
        tbl[0]  = '{1'b0, 2'b11, 16'hB1A1, 2'b00, 4'hF, 2'b11, 4'b0101, 32'h00B1_00A1};
        tbl[1]  = '{1'b0, 2'b11, 16'hB2A2, 2'b00, 4'hF, 2'b11, 4'b1010, 32'hB2B1_A2A1};
        tbl[2]  = '{1'b0, 2'b11, 16'hB3A3, 2'b00, 4'hF, 2'b11, 4'b0101, 32'hB2B3_A2A3};
        tbl[3]  = '{1'b0, 2'b00, 16'h0000, 2'b00, 4'hF, 2'b11, 4'b0000, 32'hB2B3_A2A3};
        tbl[4]  = '{1'b0, 2'b01, 16'h00A2, 2'b00, 4'hD, 2'b11, 4'b0010, 32'hB2B3_A2A3};
        tbl[5]  = '{1'b0, 2'b01, 16'h00A3, 2'b00, 4'hD, 2'b11, 4'b0011, 32'hB2B3_A2A3};
        tbl[6]  = '{1'b0, 2'b01, 16'h00A4, 2'b00, 4'hD, 2'b10, 4'b0010, 32'hB2B3_A2A3};
        tbl[7]  = '{1'b0, 2'b01, 16'h00A4, 2'b00, 4'hD, 2'b10, 4'b0010, 32'hB2B3_A2A3};
        tbl[8]  = '{1'b0, 2'b01, 16'h00A4, 2'b00, 4'hF, 2'b11, 4'b0010, 32'hB2B3_A4A3};
        tbl[9]  = '{1'b0, 2'b00, 16'h0000, 2'b00, 4'hF, 2'b11, 4'b0000, 32'hB2B3_A4A3};
        tbl[10] = '{1'b1, 2'b10, 16'hC000, 2'b10, 4'hF, 2'b11, 4'b1000, 32'hC0B3_A4A3};
        tbl[11] = '{1'b1, 2'b10, 16'hC100, 2'b10, 4'hF, 2'b11, 4'b1000, 32'hC1B3_A4A3};
        tbl[12] = '{1'b1, 2'b10, 16'hC200, 2'b10, 4'hF, 2'b11, 4'b1000, 32'hC2B3_A4A3};
        tbl[13] = '{1'b0, 2'b10, 16'hD000, 2'b00, 4'hF, 2'b11, 4'b1000, 32'hD0B3_A4A3};
        tbl[14] = '{1'b0, 2'b00, 16'h0000, 2'b00, 4'hF, 2'b11, 4'b0000, 32'hD0B3_A4A3};
        tbl[15] = '{1'b0, 2'b11, 16'h2111, 2'b00, 4'h4, 2'b11, 4'b0101, 32'hD021_A411};
        tbl[16] = '{1'b0, 2'b11, 16'h2212, 2'b00, 4'h4, 2'b11, 4'b1011, 32'h2221_1211};
        tbl[17] = '{1'b0, 2'b10, 16'h2300, 2'b00, 4'h4, 2'b10, 4'b1111, 32'h2223_1211};
        tbl[18] = '{1'b0, 2'b00, 16'h0000, 2'b00, 4'h4, 2'b00, 4'b1011, 32'h2223_1211};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_out", {92'd0, valid_out}, 96'd0);
        check("reset data_out", {64'd0, data_out}, 96'd0);
        check("reset ready_in", {94'd0, ready_in}, 96'd3);
        rst = 1'b0;

        // RATIO=3 wrap: lane0 beats must visit out0,1,2,0,1,2.
        for (int n = 0; n < 6; n++) begin
            int k;
            k = n % 3;
            valid_in3 = 2'b01;
            data_in3  = 16'h0040 + 16'(n);
            #1;
            check($sformatf("r3 beat%0d ready_in", n), {94'd0, ready_in3}, 96'd3);
            @(posedge clk);
            #1;
            check($sformatf("r3 beat%0d valid_out", n), {90'd0, valid_out3}, 96'd1 << k);
            check($sformatf("r3 beat%0d data", n), {88'd0, data_out3[k*8 +: 8]}, {88'd0, 8'h40 + 8'(n)});
            $display("r3 beat %0d: data=%h -> vout=%b", n, data_in3, valid_out3);
        end
        // Out-of-range direct select on RATIO=3 is swallowed without touching any output.
        mode3 = 1'b1; sel_in3 = 4'b0011; valid_in3 = 2'b01; data_in3 = 16'h00EE;
        #1;
        check("r3 oor ready_in", {94'd0, ready_in3}, 96'd3);
        @(posedge clk);
        #1;
        check("r3 oor valid_out", {90'd0, valid_out3}, 96'd0);
        $display("r3 oor sel=3: vout=%b", valid_out3);
        mode3 = 1'b0; sel_in3 = '0; data_in3 = 16'h0047;
        @(posedge clk);
        #1;
        check("r3 resume out0", {90'd0, valid_out3}, 96'd1);
        check("r3 resume data", {88'd0, data_out3[7:0]}, 96'h47);
        $display("r3 resume: vout=%b", valid_out3);
        valid_in3 = '0;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i], i);
        end

        // Asynchronous reset with valid_out=1011 and ptr1=1.
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid_out", {92'd0, valid_out}, 96'd0);
        check("async rst data_out", {64'd0, data_out}, 96'd0);
        check("async rst ready_in", {94'd0, ready_in}, 96'd3);
        $display("async reset: vout=%b dout=%h rin=%b", valid_out, data_out, ready_in);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step('{1'b0, 2'b11, 16'hE1E0, 2'b00, 4'hF, 2'b11, 4'b0101, 32'h00E1_00E0}, 100);

`ifdef DEMUX_RR_STATS_EN
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step('{1'b1, 2'b10, {8'h50 + 8'(n), 8'h00}, 2'b00, 4'hF, 2'b11, 4'b0100,
                   {8'h00, 8'h50 + 8'(n), 16'h0000}}, 200 + n);
        end
        step('{1'b0, 2'b00, 16'h0000, 2'b00, 4'hF, 2'b11, 4'b0000, 32'h0054_0000}, 205);
        check("stats beat_cnt", {32'd0, beat_cnt}, {32'd0, 16'd0, 16'd5, 16'd0, 16'd0});
        $display("stats: beat_cnt=%h", beat_cnt);
        #2;
        rst = 1'b1;
        #1;
        check("stats reset clear", {32'd0, beat_cnt}, 96'd0);
        $display("stats after reset: beat_cnt=%h", beat_cnt);
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/demux_rr_param.md
Name: demux_rr_param

Overview:
Parametrised successor to the 2-to-4 lane demultiplexer. It takes IN_CH input lanes, each WIDTH bits wide, and fans each lane out to its own group of RATIO output lanes, for OUT_CH = IN_CH*RATIO outputs in total. It sits between the byte-striping stage and the per-lane output FIFOs of the PHY datapath. New relative to the 2-to-4 block:
- arbitrary width, lane count and fan-out;
- a selectable direct-select mode alongside round-robin;
- valid/ready backpressure, with one registered holding stage per output lane.

Parameters:
WIDTH, 8, data bits per lane (>=1)
IN_CH, 2, number of input lanes (>=1)
RATIO, 2, outputs per input lane (>=1); OUT_CH = IN_CH*RATIO is a localparam
SELW, derived localparam = max(1, clog2(RATIO)), width of each per-lane select field

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = round-robin distribution, 1 = direct select via sel_in
valid_in  in  IN_CH  per-input-lane beat valid
data_in  in  IN_CH*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
sel_in  in  IN_CH*SELW  lane i target index (0..RATIO-1); used only when mode=1
ready_in  out  IN_CH  per-input-lane accept
valid_out  out  OUT_CH  per-output-lane valid
data_out  out  OUT_CH*WIDTH  output lane j occupies bits [j*WIDTH +: WIDTH]
ready_out  in  OUT_CH  downstream accept per output lane

Behaviour:
- Reset (asynchronous, active-high):
  - valid_out = 0 and data_out = 0 on every lane.
  - All round-robin pointers = 0.
  - ready_in follows combinationally from the cleared state, so it is all 1s while reset is held.
- Output groups: input lane i owns output lanes j = i*RATIO + k, k = 0..RATIO-1. Lanes never cross groups.
- Target index tgt_i:
  - mode=0: tgt_i = ptr_i, a SELW-bit counter per lane.
  - mode=1: tgt_i = sel_in field i.
- Holding register: each output lane is one registered stage (valid_out[j], data_out[j]).
- Input ready: ready_in[i] = !valid_out[t] || ready_out[t], where t = i*RATIO + tgt_i. This is combinational and has no path from valid_in.
- Accept: a beat is accepted when valid_in[i] && ready_in[i].
  - At the next edge, data_out[t] <= data_in[i] and valid_out[t] <= 1.
  - Latency is 1 cycle.
- Drain: when valid_out[j] && ready_out[j] and no new beat lands on j, valid_out[j] <= 0. data_out holds its last value.
- Simultaneous drain and load on the same lane: the new beat is loaded and valid stays 1. Full throughput of 1 beat/cycle per input lane is supported.
- Pointer update (mode=0 only):
  - ptr_i advances on each accepted beat.
  - It wraps RATIO-1 -> 0, including when RATIO is not a power of two.
- Stall: if the target output is full and not draining, ready_in[i] = 0. The pointer holds and the beat is not skipped or dropped. Other lanes are unaffected.
- mode=1:
  - Pointers hold their value.
  - If sel_in field i >= RATIO: ready_in[i] = 1, the beat is accepted and discarded, and no output changes.
- Mode switch: takes effect on the next cycle's target computation. Pointers are not reset, so returning to mode=0 resumes from the stored ptr_i.
- RATIO=1: pure 1-stage registered pass-through per lane with backpressure.
- Reset asserted mid-stream: beats in flight are lost. After reset releases, distribution restarts at k=0.

Optional Feature:
DEMUX_RR_STATS_EN
- Defined:
  - Adds output port beat_cnt, width OUT_CH*16.
  - One 16-bit counter per output lane, incremented on each valid_out[j] && ready_out[j] handshake.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: no port and no counters; behaviour is otherwise identical.

Test Plan:
1. IN_CH=2, RATIO=2, WIDTH=8, mode=0, all ready_out=1. Lane0 sends 0xA1,0xA2,0xA3 and lane1 sends 0xB1,0xB2,0xB3 on consecutive cycles. Required: out0=0xA1,0xA3; out1=0xA2; out2=0xB1,0xB3; out3=0xB2; each appears 1 cycle after input.
2. Backpressure: ready_out[1]=0 while out1 holds 0xA2. The next lane0 beat 0xA3 targets out0 and lands. The beat after, 0xA4, targets out1: ready_in[0]=0 until ready_out[1]=1, then 0xA4 appears on out1. No beats are lost or duplicated.
3. mode=1, lane1 sel_in=1, three beats 0xC0..0xC2. Required: all three appear on out3, out2 stays idle, ptr_1 is unchanged.
4. RATIO=3, mode=0, six beats on lane0. Required: out0/1/2/0/1/2 order, confirming non-power-of-two wrap.
5. Reset asserted while valid_out=4'b1011. Required: valid_out=0 and data_out=0 immediately (asynchronous). The first post-reset beat goes to k=0.
6. With DEMUX_RR_STATS_EN defined: 5 handshakes on out2. Required: beat_cnt lane2 = 5 and all other lanes 0; reset clears the counts.
